// File: rtl/nibble_lane_sched_pkg.sv
// Shared types and default sizes for the nibble lane write scheduler.
package nibble_lane_sched_pkg;

    localparam int unsigned NREQ_DEF   = 4;
    localparam int unsigned NLANES_DEF = 8;
    localparam int unsigned LW_DEF     = 4;

    typedef enum logic [0:0] {IDLE, HOLD} state_e;

    typedef logic [$clog2(NLANES_DEF)-1:0] lane_idx_t;
    typedef logic [LW_DEF-1:0]             lane_t;

    // Index width that stays at least one bit for degenerate sizes.
    function automatic int unsigned idx_width(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arb.sv
// N-wide round-robin arbiter: the search starts at ptr_i and ascends with wrap.
module rr_arb #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    input  logic          en_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    // First requester at or after the pointer wins; nothing is granted when disabled.
    always_comb begin
        int unsigned cand;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = 0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = (32'(ptr_i) + k) % N;
            if (en_i && !any_o && req_i[cand]) begin
                any_o       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/nibble_lane_sched.sv
// Round-robin write scheduler for a packed array of lanes, with a snapshot
// capture/hold/ack path. The optional write counter output wr_count is built
// when NIBBLE_LANE_SCHED_WRCNT_EN is defined.
module nibble_lane_sched
    import nibble_lane_sched_pkg::*;
#(
    parameter int unsigned NREQ   = NREQ_DEF,
    parameter int unsigned NLANES = NLANES_DEF,
    parameter int unsigned LW     = LW_DEF,
    localparam int unsigned LIW   = (NLANES > 1) ? $clog2(NLANES) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*LIW-1:0]  req_lane,
    input  logic [NREQ*LW-1:0]   req_data,
    output logic [NLANES*LW-1:0] lanes_out,
    input  logic                 snap_req,
    output logic                 snap_valid,
    output logic [NLANES*LW-1:0] snap_data,
    input  logic                 snap_ack
`ifdef NIBBLE_LANE_SCHED_WRCNT_EN
    ,
    output logic [15:0]          wr_count
`endif
);

    localparam int unsigned PIW = idx_width(NREQ);

    state_e                    state_q, state_d;
    logic [PIW-1:0]            ptr_q, ptr_d;
    logic [NLANES-1:0][LW-1:0] lanes_q, lanes_d;
    logic [NLANES*LW-1:0]      snap_q, snap_d;

    logic            arb_en;
    logic            gnt_any;
    logic [PIW-1:0]  gnt_idx;
    logic [NREQ-1:0] gnt;
    logic [LIW-1:0]  win_lane;
    logic [LW-1:0]   win_data;

    // Snapshot requests beat writes; reset also masks every grant.
    assign arb_en = rst_n && (state_q == IDLE) && !snap_req;

    rr_arb #(
        .N  (NREQ),
        .IW (PIW)
    ) u_arb (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .en_i  (arb_en),
        .gnt_o (gnt),
        .idx_o (gnt_idx),
        .any_o (gnt_any)
    );

    assign req_ready = gnt;
    assign win_lane  = req_lane[32'(gnt_idx) * LIW +: LIW];
    assign win_data  = req_data[32'(gnt_idx) * LW +: LW];

    // Next-state: snapshot capture, handshake release, lane write and pointer advance.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        lanes_d = lanes_q;
        snap_d  = snap_q;
        unique case (state_q)
            IDLE: begin
                if (snap_req) begin
                    snap_d  = lanes_q;
                    state_d = HOLD;
                end else if (gnt_any) begin
                    // Out-of-range lane indices still consume the grant but write nothing.
                    if (32'(win_lane) < NLANES) begin
                        lanes_d[win_lane] = win_data;
                    end
                    ptr_d = (gnt_idx == PIW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
                end
            end
            HOLD: begin
                if (snap_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            lanes_q <= '0;
            snap_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            lanes_q <= lanes_d;
            snap_q  <= snap_d;
        end
    end

    assign lanes_out  = lanes_q;
    assign snap_data  = snap_q;
    assign snap_valid = (state_q == HOLD);

`ifdef NIBBLE_LANE_SCHED_WRCNT_EN
    logic [15:0] wr_cnt_q, wr_cnt_d;

    // Saturating count of accepted writes, cleared when a snapshot is captured.
    always_comb begin
        wr_cnt_d = wr_cnt_q;
        if ((state_q == IDLE) && snap_req) begin
            wr_cnt_d = '0;
        end else if (gnt_any && (wr_cnt_q != 16'hFFFF)) begin
            wr_cnt_d = wr_cnt_q + 16'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_cnt_q <= '0;
        end else begin
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign wr_count = wr_cnt_q;
`endif

endmodule

// File: tb/tb_nibble_lane_sched.sv
// Self-checking bench for nibble_lane_sched against a lane-array reference model.
module tb_nibble_lane_sched;
    import nibble_lane_sched_pkg::*;

    localparam int unsigned NREQ   = 4;
    localparam int unsigned NLANES = 8;
    localparam int unsigned LW     = 4;
    localparam int unsigned LIW    = 3;
    localparam int unsigned W      = NLANES * LW;
    localparam int unsigned LANEW  = NREQ * LIW;
    localparam int unsigned DATAW  = NREQ * LW;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NREQ-1:0]  req_valid = '0;
    logic [NREQ-1:0]  req_ready;
    logic [LANEW-1:0] req_lane = '0;
    logic [DATAW-1:0] req_data = '0;
    logic [W-1:0]     lanes_out;
    logic             snap_req = 1'b0;
    logic             snap_valid;
    logic [W-1:0]     snap_data;
    logic             snap_ack = 1'b0;
`ifdef NIBBLE_LANE_SCHED_WRCNT_EN
    logic [15:0]      wr_count;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    nibble_lane_sched dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_lane   (req_lane),
        .req_data   (req_data),
        .lanes_out  (lanes_out),
        .snap_req   (snap_req),
        .snap_valid (snap_valid),
        .snap_data  (snap_data),
        .snap_ack   (snap_ack)
`ifdef NIBBLE_LANE_SCHED_WRCNT_EN
        ,
        .wr_count   (wr_count)
`endif
    );

    // Reference model state
    lane_t       lanes_m [NLANES];
    logic [W-1:0] snap_m = '0;
    bit          hold_m = 1'b0;
    int unsigned ptr_m = 0;
    int unsigned cnt_m = 0;

    function automatic logic [NREQ-1:0] exp_ready();
        logic [NREQ-1:0] r = '0;
        if (rst_n !== 1'b1 || hold_m || snap_req) return r;
        for (int k = 0; k < NREQ; k++) begin
            int i = (int'(ptr_m) + k) % NREQ;
            if (req_valid[i]) begin
                r[i] = 1'b1;
                return r;
            end
        end
        return r;
    endfunction

    function automatic logic [W-1:0] exp_lanes();
        logic [W-1:0] r = '0;
        for (int i = 0; i < NLANES; i++) r[i*LW +: LW] = lanes_m[i];
        return r;
    endfunction

    function automatic void model_update();
        logic [NREQ-1:0] g = exp_ready();
        if (!rst_n) begin
            for (int i = 0; i < NLANES; i++) lanes_m[i] = '0;
            snap_m = '0;
            hold_m = 1'b0;
            ptr_m  = 0;
            cnt_m  = 0;
        end else if (hold_m) begin
            if (snap_ack) hold_m = 1'b0;
        end else if (snap_req) begin
            snap_m = exp_lanes();
            hold_m = 1'b1;
            cnt_m  = 0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (g[i]) begin
                    int unsigned ln = 32'(req_lane[i*LIW +: LIW]);
                    if (ln < NLANES) lanes_m[ln] = req_data[i*LW +: LW];
                    ptr_m = (i + 1) % NREQ;
                    if (cnt_m < 65535) cnt_m++;
                end
            end
        end
    endfunction

    // Advance one clock edge, keeping the model in lockstep.
    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic set_idle();
        req_valid = '0;
        req_lane  = '0;
        req_data  = '0;
        snap_req  = 1'b0;
        snap_ack  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        set_idle();
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        @(negedge clk);
        set_idle();
        rst_n     = 1'b0;
        req_valid = '1;
        #1;
        n_checks++;
        if (req_ready !== 4'b0000) $display("FAIL reset_ready: got %b want 0000", req_ready);
        else n_pass++;
        tick();
        @(negedge clk);
        tick();
        n_checks++;
        if (lanes_out !== 32'h0) $display("FAIL reset_lanes: got %h want 0", lanes_out);
        else n_pass++;
        n_checks++;
        if (snap_valid !== 1'b0) $display("FAIL reset_snap_valid: got %b want 0", snap_valid);
        else n_pass++;
        n_checks++;
        if (snap_data !== 32'h0) $display("FAIL reset_snap_data: got %h want 0", snap_data);
        else n_pass++;
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = '0;
        #1;
        n_checks++;
        if (req_ready !== 4'b0000) $display("FAIL idle_ready: got %b want 0000", req_ready);
        else n_pass++;
        tick();
        n_checks++;
        if (lanes_out !== 32'h0) $display("FAIL idle_lanes: got %h want 0", lanes_out);
        else n_pass++;
    endtask

    task automatic test_single_write();
        do_reset();
        @(negedge clk);
        req_valid     = 4'b0001;
        req_lane[2:0] = 3'd3;
        req_data[3:0] = 4'hA;
        #1;
        n_checks++;
        if (req_ready !== 4'b0001) $display("FAIL single_ready: got %b want 0001", req_ready);
        else n_pass++;
        tick();
        n_checks++;
        if (lanes_out !== 32'h0000_A000)
            $display("FAIL single_lanes: got %h want 0000a000", lanes_out);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            req_valid = '1;
            for (int i = 0; i < NREQ; i++) begin
                req_lane[i*LIW +: LIW] = LIW'(i);
                req_data[i*LW +: LW]   = LW'(i + 1);
            end
            #1;
            n_checks++;
            if (req_ready !== (NREQ'(1) << (k % 4)))
                $display("FAIL rr_grant%0d: got %b want %b", k, req_ready, NREQ'(1) << (k % 4));
            else n_pass++;
            tick();
        end
        n_checks++;
        if (lanes_out !== 32'h0000_4321) $display("FAIL rr_lanes: got %h want 00004321", lanes_out);
        else n_pass++;
    endtask

    task automatic test_same_lane();
        do_reset();
        @(negedge clk);
        req_valid     = 4'b0001;
        req_lane[2:0] = 3'd0;
        req_data[3:0] = 4'h1;
        tick();
        @(negedge clk);
        set_idle();
        req_valid     = 4'b0110;
        req_lane[5:3] = 3'd5;
        req_data[7:4] = 4'h7;
        req_lane[8:6] = 3'd5;
        req_data[11:8] = 4'h9;
        #1;
        n_checks++;
        if (req_ready !== 4'b0010) $display("FAIL same_first: got %b want 0010", req_ready);
        else n_pass++;
        tick();
        n_checks++;
        if (lanes_out[23:20] !== 4'h7) $display("FAIL same_mid: got %h want 7", lanes_out[23:20]);
        else n_pass++;
        @(negedge clk);
        #1;
        n_checks++;
        if (req_ready !== 4'b0100) $display("FAIL same_second: got %b want 0100", req_ready);
        else n_pass++;
        tick();
        n_checks++;
        if (lanes_out !== 32'h0090_0001) $display("FAIL same_final: got %h want 00900001", lanes_out);
        else n_pass++;
`ifdef NIBBLE_LANE_SCHED_WRCNT_EN
        n_checks++;
        if (wr_count !== 16'd3) $display("FAIL same_wrcnt: got %0d want 3", wr_count);
        else n_pass++;
`endif
    endtask

    task automatic test_snapshot();
        do_reset();
`ifdef NIBBLE_LANE_SCHED_WRCNT_EN
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            req_valid     = 4'b0001;
            req_lane[2:0] = LIW'(k);
            req_data[3:0] = 4'h0;
            tick();
        end
        n_checks++;
        if (wr_count !== 16'd2) $display("FAIL snap_wrcnt2: got %0d want 2", wr_count);
        else n_pass++;
`endif
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            req_valid     = 4'b0001;
            req_lane[2:0] = LIW'(k);
            req_data[3:0] = LW'(k + 1);
            tick();
        end
        n_checks++;
        if (lanes_out !== 32'h8765_4321) $display("FAIL snap_fill: got %h want 87654321", lanes_out);
        else n_pass++;
        @(negedge clk);
        snap_req      = 1'b1;
        req_lane[2:0] = 3'd0;
        req_data[3:0] = 4'hF;
        #1;
        n_checks++;
        if (req_ready !== 4'b0000) $display("FAIL snap_block: got %b want 0000", req_ready);
        else n_pass++;
        tick();
        n_checks++;
        if (snap_valid !== 1'b1 || snap_data !== 32'h8765_4321)
            $display("FAIL snap_capture: got %b/%h want 1/87654321", snap_valid, snap_data);
        else n_pass++;
`ifdef NIBBLE_LANE_SCHED_WRCNT_EN
        n_checks++;
        if (wr_count !== 16'd0) $display("FAIL snap_wrcnt_clr: got %0d want 0", wr_count);
        else n_pass++;
`endif
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            snap_req = 1'b0;
            #1;
            n_checks++;
            if (req_ready !== 4'b0000 || snap_valid !== 1'b1 || snap_data !== 32'h8765_4321)
                $display("FAIL snap_hold%0d: got %b/%b/%h want 0000/1/87654321",
                         k, req_ready, snap_valid, snap_data);
            else n_pass++;
            tick();
        end
        @(negedge clk);
        snap_ack = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 4'b0000) $display("FAIL snap_ack_cycle: got %b want 0000", req_ready);
        else n_pass++;
        tick();
        @(negedge clk);
        snap_ack = 1'b0;
        #1;
        n_checks++;
        if (snap_valid !== 1'b0 || req_ready !== 4'b0001)
            $display("FAIL snap_release: got %b/%b want 0/0001", snap_valid, req_ready);
        else n_pass++;
        tick();
        n_checks++;
        if (lanes_out !== 32'h8765_432F) $display("FAIL snap_resume: got %h want 8765432f", lanes_out);
        else n_pass++;
    endtask

    task automatic test_reset_in_hold();
        do_reset();
        @(negedge clk);
        req_valid     = 4'b0001;
        req_lane[2:0] = 3'd6;
        req_data[3:0] = 4'hC;
        tick();
        @(negedge clk);
        set_idle();
        snap_req = 1'b1;
        tick();
        n_checks++;
        if (snap_valid !== 1'b1 || snap_data !== 32'h0C00_0000)
            $display("FAIL hold_enter: got %b/%h want 1/0c000000", snap_valid, snap_data);
        else n_pass++;
        @(negedge clk);
        snap_req = 1'b0;
        rst_n    = 1'b0;
        tick();
        n_checks++;
        if (snap_valid !== 1'b0 || lanes_out !== 32'h0 || snap_data !== 32'h0)
            $display("FAIL hold_reset: got %b/%h/%h want 0/0/0", snap_valid, lanes_out, snap_data);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            rst_n     = ($urandom_range(0, 99) != 0);
            req_valid = NREQ'($urandom);
            req_lane  = LANEW'($urandom);
            req_data  = DATAW'($urandom);
            snap_req  = ($urandom_range(0, 9) == 0);
            snap_ack  = ($urandom_range(0, 2) == 0);
            #1;
            n_checks++;
            if (req_ready !== exp_ready())
                $display("FAIL rnd_ready@%0d: got %b want %b", c, req_ready, exp_ready());
            else n_pass++;
            tick();
            n_checks++;
            if (lanes_out !== exp_lanes() || snap_valid !== hold_m || snap_data !== snap_m)
                $display("FAIL rnd_state@%0d: got %h/%b/%h want %h/%b/%h", c, lanes_out,
                         snap_valid, snap_data, exp_lanes(), hold_m, snap_m);
            else n_pass++;
`ifdef NIBBLE_LANE_SCHED_WRCNT_EN
            n_checks++;
            if (wr_count !== 16'(cnt_m))
                $display("FAIL rnd_wrcnt@%0d: got %0d want %0d", c, wr_count, cnt_m);
            else n_pass++;
`endif
        end
        @(negedge clk);
        set_idle();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_round_robin();
        test_same_lane();
        test_snapshot();
        test_reset_in_hold();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
